// File: rtl/div_pkg.sv
// Shared controller state encoding and default divisor width for the div_8x4 divider.
package div_pkg;

    localparam int DIV_SIZE_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_8x4_cu.sv
// Sequencing controller for the div_8x4 restoring divider: turns counter-done and
// compare-result into shift/sub/cnt_up strobes plus busy/done status.
module div_8x4_cu
    import div_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic dbz_start,
    input  logic cnt_done,
    input  logic cmp_ge,
    output logic load,
    output logic shift,
    output logic sub,
    output logic cnt_up,
    output logic q_bit,
    output logic finish,
    output logic busy,
    output logic done
);

    div_state_t state_reg;
    logic       shift_reg;
    logic       sub_reg;
    logic       busy_reg;
    logic       done_reg;

    assign load   = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign shift  = shift_reg;
    assign sub    = sub_reg;
    assign cnt_up = sub_reg;
    assign q_bit  = sub_reg & cmp_ge;
    // Last SUB of the run: the datapath latches its result on this edge.
    assign finish = sub_reg & cnt_done;
    assign busy   = busy_reg;
    assign done   = done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            shift_reg <= 1'b0;
            sub_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        if (dbz_start) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= SHIFT;
                            shift_reg <= 1'b1;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    state_reg <= SUB;
                    shift_reg <= 1'b0;
                    sub_reg   <= 1'b1;
                end
                SUB: begin
                    sub_reg <= 1'b0;
                    if (cnt_done) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= SHIFT;
                        shift_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/div_8x4.sv
// Restoring shift-subtract divider, 2*SIZE-bit dividend by SIZE-bit divisor.
// Define DIV_8X4_DBZ_CHECK_EN to short-circuit a zero divisor straight to DONE.
module div_8x4
    import div_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2*SIZE-1:0]   dividend,
    input  logic [SIZE-1:0]     divisor,
    output logic [2*SIZE-1:0]   quotient,
    output logic [SIZE-1:0]     remainder,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero
);

    localparam int CW = $clog2(2*SIZE) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(2*SIZE - 1);

    logic [SIZE:0]       rem_reg;
    logic [2*SIZE-1:0]   dq_reg;
    logic [SIZE-1:0]     dvs_reg;
    logic [CW-1:0]       cnt_reg;
    logic [2*SIZE-1:0]   quo_reg;
    logic [SIZE-1:0]     remo_reg;

    logic [SIZE:0]       rem_sub;
    logic [SIZE:0]       rem_res;
    logic                cmp_ge;
    logic                cnt_done;
    logic                dbz_start;
    logic                load;
    logic                shift;
    logic                sub;
    logic                cnt_up;
    logic                q_bit;
    logic                finish;

    assign cmp_ge   = (rem_reg >= {1'b0, dvs_reg});
    assign rem_sub  = rem_reg - {1'b0, dvs_reg};
    assign rem_res  = q_bit ? rem_sub : rem_reg;
    // Sampled before the increment, so this marks the final SUB.
    assign cnt_done = (cnt_reg == CNT_LAST);

    div_8x4_cu u_cu (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dbz_start (dbz_start),
        .cnt_done  (cnt_done),
        .cmp_ge    (cmp_ge),
        .load      (load),
        .shift     (shift),
        .sub       (sub),
        .cnt_up    (cnt_up),
        .q_bit     (q_bit),
        .finish    (finish),
        .busy      (busy),
        .done      (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_reg  <= '0;
            dq_reg   <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            quo_reg  <= '0;
            remo_reg <= '0;
        end else begin
            if (load) begin
                rem_reg <= '0;
                dq_reg  <= dividend;
                dvs_reg <= divisor;
                cnt_reg <= '0;
            end else if (shift) begin
                {rem_reg, dq_reg} <= {rem_reg[SIZE-1:0], dq_reg, 1'b0};
            end else if (sub) begin
                rem_reg   <= rem_res;
                dq_reg[0] <= q_bit;
            end
            if (cnt_up) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            // Results only move at completion so they hold through DONE/IDLE.
            if (load && dbz_start) begin
                quo_reg  <= '1;
                remo_reg <= '0;
            end else if (finish) begin
                quo_reg  <= {dq_reg[2*SIZE-1:1], q_bit};
                remo_reg <= rem_res[SIZE-1:0];
            end
        end
    end

    assign quotient  = quo_reg;
    assign remainder = remo_reg;

`ifdef DIV_8X4_DBZ_CHECK_EN
    logic dbz_reg;

    assign dbz_start = (divisor == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbz_reg <= 1'b0;
        end else if (load) begin
            dbz_reg <= dbz_start;
        end
    end

    assign div_by_zero = dbz_reg;
`else
    assign dbz_start   = 1'b0;
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_8x4.sv
// Self-checking bench for div_8x4: directed corner cases plus randomized divisions
// compared every cycle against a countdown/arithmetic reference model.
module tb_div_8x4;
    import div_pkg::*;

`ifdef DIV_8X4_DBZ_CHECK_EN
    localparam bit DBZ = 1'b1;
`else
    localparam bit DBZ = 1'b0;
`endif
    localparam int LAT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    div_8x4 #(.SIZE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic int exp_q(input int a, input int b);
        return (b == 0) ? 255 : a / b;
    endfunction

    function automatic int exp_r(input int a, input int b);
        if (b == 0) return DBZ ? 0 : (a % 16);
        return a % b;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reference model: what the outputs must be after each edge.
    int m_q = 0, m_r = 0, m_left = 0;
    bit m_busy = 0, m_done = 0, m_dbz = 0;
    int p_q = 0, p_r = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_q = 0; m_r = 0; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r;
            end
        end else if (start) begin
            p_q = exp_q(int'(dividend), int'(divisor));
            p_r = exp_r(int'(dividend), int'(divisor));
            m_done = 0; m_dbz = 0;
            if (DBZ && divisor == 4'd0) begin
                m_done = 1; m_dbz = 1; m_q = p_q; m_r = p_r;
            end else begin
                m_busy = 1; m_left = LAT;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_quotient", 32'(quotient), 32'(m_q));
            chk("cyc_remainder", 32'(remainder), 32'(m_r));
            chk("cyc_dbz", 32'(div_by_zero), 32'(m_dbz));
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Drives start for one accepting edge; returns just after that edge.
    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        dividend = a; divisor = b; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Counts further edges until done (0 = done already after the accepting edge).
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL wait_done: done not seen within 40 edges, expected 1");
        end
    endtask

    task automatic run_div(input string name, input logic [7:0] a, input logic [3:0] b,
                           input int want_q, input int want_r, input int want_lat);
        int lat;
        launch(a, b);
        wait_done(0, lat);
        chk({name, "_lat"}, 32'(lat), 32'(want_lat));
        chk({name, "_q"}, 32'(quotient), 32'(want_q));
        chk({name, "_r"}, 32'(remainder), 32'(want_r));
        $display("txn %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", name, a, b,
                 quotient, remainder, div_by_zero, lat);
    endtask

    initial begin
        int lat;
        bit saw_done;
        #1 reset = 1'b0;
        repeat (3) step();
        run_cmp = 1'b1;
        chk("reset_q", 32'(quotient), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset = 1'b1;
        step();

        run_div("200/7", 8'd200, 4'd7, 28, 4, 16);
        run_div("255/15", 8'd255, 4'd15, 17, 0, 16);
        run_div("13/14", 8'd13, 4'd14, 0, 13, 16);
        run_div("100/0", 8'd100, 4'd0, 255, DBZ ? 0 : 4, DBZ ? 0 : 16);
        chk("100/0_dbz", 32'(div_by_zero), 32'(DBZ));

        // Start pulsed while busy must be ignored.
        launch(8'd200, 4'd7);
        repeat (4) step();
        dividend = 8'd90; divisor = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(5, lat);
        chk("ignore_lat", 32'(lat), 32'd16);
        chk("ignore_q", 32'(quotient), 32'd28);
        chk("ignore_r", 32'(remainder), 32'd4);
        $display("txn ignore: 200/7 with 90/9 at edge 5 -> q=%0d r=%0d", quotient, remainder);

        // New start after completion clears done on the accepting edge.
        launch(8'd144, 4'd12);
        chk("restart_done_clr", 32'(done), 32'd0);
        wait_done(0, lat);
        chk("restart_q", 32'(quotient), 32'd12);
        chk("restart_r", 32'(remainder), 32'd0);
        $display("txn restart: 144/12 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);

        // Reset mid-division aborts it.
        launch(8'd200, 4'd7);
        repeat (7) step();
        reset = 1'b0;
        #1;
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        chk("abort_state", 32'(dut.u_cu.state_reg == IDLE), 32'd1);
        step();
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            step();
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        $display("txn abort: reset at edge 8, done afterwards=%0d", saw_done);

        for (int t = 0; t < 120; t++) begin
            logic [7:0] a;
            logic [3:0] b;
            int k;
            bit zero_path;
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            zero_path = DBZ && (b == 4'd0);
            launch(a, b);
            k = 0;
            if (!zero_path && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(1, 14);
                repeat (k - 1) step();
                dividend = 8'($urandom); divisor = 4'($urandom); start = 1'b1;
                step();
                start = 1'b0;
            end
            wait_done(k, lat);
            chk("rnd_lat", 32'(lat), zero_path ? 32'd0 : 32'd16);
            chk("rnd_q", 32'(quotient), 32'(exp_q(int'(a), int'(b))));
            chk("rnd_r", 32'(remainder), 32'(exp_r(int'(a), int'(b))));
            $display("txn rnd%0d: %0d / %0d -> q=%0d r=%0d lat=%0d inject=%0d",
                     t, a, b, quotient, remainder, lat, k);
            repeat ($urandom_range(0, 3)) step();
        end

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_8x4.md
DIV_8X4 -- requirements
Module: div_8x4

Interface
REQ-001 The block SHALL have parameter SIZE, default 4, giving divisor width; dividend and quotient are 2*SIZE bits.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  one-cycle request, already debounced and synchronous to clk.
REQ-005 The block SHALL have port dividend  input  2*SIZE  unsigned dividend, sampled only on an accepted start.
REQ-006 The block SHALL have port divisor  input  SIZE  unsigned divisor, sampled only on an accepted start.
REQ-007 The block SHALL have port quotient  output  2*SIZE  unsigned quotient, registered.
REQ-008 The block SHALL have port remainder  output  SIZE  unsigned remainder, registered.
REQ-009 The block SHALL have port busy  output  1  high while a division is in progress.
REQ-010 The block SHALL have port done  output  1  high from completion until the next accepted start.
REQ-011 The block SHALL have port div_by_zero  output  1  set on completion when the sampled divisor is 0.

Function
REQ-012 The block SHALL implement restoring shift-subtract division: a SIZE+1-bit partial remainder and a 2*SIZE-bit dividend/quotient shift register.
REQ-013 The controller SHALL have states IDLE, SHIFT, SUB and DONE.
REQ-014 In IDLE or DONE, start high SHALL be accepted: operands load, the iteration counter clears, done and div_by_zero clear, busy sets and the state goes to SHIFT.
REQ-015 SHIFT SHALL left-shift {partial remainder, dividend register} by one bit, then go to SUB.
REQ-016 SUB SHALL compare the partial remainder against the divisor. If partial remainder >= divisor, it SHALL subtract the divisor and set the new quotient LSB to 1; otherwise it SHALL keep the partial remainder and set the LSB to 0. The counter SHALL then increment.
REQ-017 After SUB, if the counter equals 2*SIZE, the state SHALL go to DONE; otherwise it SHALL go back to SHIFT.
REQ-018 done SHALL rise on the 4*SIZE-th rising edge after the accepting edge (16 for SIZE=4), and busy SHALL fall on that same edge.
REQ-019 quotient and remainder SHALL hold their final values, unchanged, in DONE and IDLE until the next accepted start.
REQ-020 start SHALL be ignored while busy is high, with no effect on state, operands or outputs.
REQ-021 The remainder SHALL always be less than the divisor for a nonzero divisor; all arithmetic is unsigned, with no overflow possible.

Reset
REQ-022 While reset is low, the block SHALL asynchronously force state IDLE, counter 0, quotient 0, remainder 0, busy 0, done 0 and div_by_zero 0.
REQ-023 Reset asserted mid-division SHALL abort that division; no done pulse SHALL follow its release.

Configuration
REQ-024 With macro DIV_8X4_DBZ_CHECK_EN defined, an accepted start with divisor 0 SHALL go straight to DONE on the next edge, giving quotient all-ones, remainder 0 and div_by_zero 1.
REQ-025 Without DIV_8X4_DBZ_CHECK_EN, div_by_zero SHALL be tied to 0. A zero divisor SHALL run full latency and yield quotient all-ones and remainder equal to dividend[SIZE-1:0].

Structure
REQ-026 The state encoding and the default SIZE SHALL live in shared package div_pkg.
REQ-027 Control SHALL be the sub-module div_8x4_cu, which drives the shift, sub and cnt_up strobes from the counter-done and compare-result inputs. The datapath stays in div_8x4.

Verification
REQ-028 With dividend 200 and divisor 7, the bench SHALL see quotient 28, remainder 4 and done on edge 16.
REQ-029 With dividend 255 and divisor 15, the bench SHALL see quotient 17 and remainder 0. With dividend 13 and divisor 14, it SHALL see quotient 0 and remainder 13.
REQ-030 With dividend 100 and divisor 0 and the macro defined, the bench SHALL see done after 1 edge, quotient 0xFF, remainder 0 and div_by_zero 1. Without the macro, it SHALL see done on edge 16, quotient 0xFF, remainder 4 and div_by_zero 0.
REQ-031 Starting 200/7, then pulsing start with 90/9 at edge 5, the bench SHALL see the second start ignored and quotient 28, remainder 4.
REQ-032 Pulsing reset low at edge 8 of a division, the bench SHALL see all outputs 0 immediately, state IDLE, and no done afterward.
REQ-033 After a completed division, a new start with 144/12 SHALL clear done on the accepting edge and produce quotient 12, remainder 0.
